// File: rtl/mapper_mem_responder.sv
// -----------------------------------------------------------------------------
// mapper_mem_responder
//
// Memory-side responder for the slot mapper. Each assertion of ram_cs runs
// exactly one memory-controller transaction (or none, on a cache hit). The CPU
// is stalled through cpu_wait until the transaction has finished, and read data
// is then returned on cpu_data_out. A watchdog aborts transactions that never
// receive mem_ack.
//
// Parameters
//   ADDR_WIDTH      width of ram_addr / mem_addr
//   TIMEOUT_CYCLES  maximum BUSY cycles without mem_ack; 0 disables the watchdog
//
// Optional feature
//   MAPPER_LAST_READ_CACHE_EN  single-entry last-read cache (valid, tag, data)
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   ram_cs         mapper chip select (level, held for the CPU bus cycle)
//   ram_addr       mapper address
//   ram_rnw        1 = read, 0 = write
//   cpu_data_in    CPU write data
//   cpu_data_out   registered read data to the CPU
//   cpu_wait       combinational CPU stall request
//   mem_req        registered memory request level
//   mem_we         1 = write, valid while mem_req
//   mem_addr       latched address, valid while mem_req
//   mem_din        latched write data, valid while mem_req
//   mem_dout       memory read data, valid with mem_ack
//   mem_ack        single-cycle completion pulse
//   timeout_err    single-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module mapper_mem_responder #(
    parameter int ADDR_WIDTH     = 27,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_cs,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_rnw,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_wait,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_din,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_ack,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_e                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]              mem_din_q, mem_din_d;
    logic [7:0]              cpu_data_q, cpu_data_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [31:0]             wdog_q, wdog_d;

    logic                    wd_expire_s;
    logic                    cache_hit_s;
    logic [7:0]              cache_rdata_s;

    // Watchdog fires in the last allowed BUSY cycle; the counter started at 0
    // in the first BUSY cycle, so TIMEOUT_CYCLES BUSY cycles have elapsed.
    assign wd_expire_s = WD_EN && (wdog_q == WD_LAST);

`ifdef MAPPER_LAST_READ_CACHE_EN
    logic                    cache_valid_q, cache_valid_d;
    logic [ADDR_WIDTH-1:0]   cache_tag_q, cache_tag_d;
    logic [7:0]              cache_data_q, cache_data_d;

    assign cache_hit_s   = ram_rnw && cache_valid_q && (cache_tag_q == ram_addr);
    assign cache_rdata_s = cache_data_q;

    // Cache entry update: fill on completed reads, refresh on writes to the
    // cached address, invalidate on watchdog abort.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if ((state_q == ST_BUSY) && mem_ack) begin
            if (!mem_we_q) begin
                cache_valid_d = 1'b1;
                cache_tag_d   = mem_addr_q;
                cache_data_d  = mem_dout;
            end else if (cache_valid_q && (cache_tag_q == mem_addr_q)) begin
                cache_data_d  = mem_din_q;
            end else begin
                cache_data_d  = cache_data_q;
            end
        end else if ((state_q == ST_BUSY) && wd_expire_s) begin
            cache_valid_d = 1'b0;
        end else begin
            cache_valid_d = cache_valid_q;
        end
    end

    // Cache entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= 8'h00;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end
`else
    assign cache_hit_s   = 1'b0;
    assign cache_rdata_s = 8'h00;
`endif

    // Next-state and registered-output logic of the transaction FSM.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        cpu_data_d    = cpu_data_q;
        timeout_err_d = 1'b0;
        wdog_d        = wdog_q;

        case (state_q)
            ST_IDLE: begin
                if (ram_cs && cache_hit_s) begin
                    // Served from the cache: no memory request at all.
                    cpu_data_d = cache_rdata_s;
                    state_d    = ST_DONE;
                end else if (ram_cs) begin
                    mem_addr_d = ram_addr;
                    mem_we_d   = ~ram_rnw;
                    mem_din_d  = cpu_data_in;
                    mem_req_d  = 1'b1;
                    wdog_d     = 32'd0;
                    state_d    = ST_BUSY;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // ack takes priority over a simultaneous watchdog expiry
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_data_d = mem_dout;
                    end else begin
                        cpu_data_d = cpu_data_q;
                    end
                    state_d = ST_DONE;
                end else if (wd_expire_s) begin
                    mem_req_d     = 1'b0;
                    cpu_data_d    = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end

            ST_DONE: begin
                // Hold until the CPU releases cs: one access per assertion.
                if (!ram_cs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= 8'h00;
            cpu_data_q    <= 8'hFF;
            timeout_err_q <= 1'b0;
            wdog_q        <= 32'd0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            cpu_data_q    <= cpu_data_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    // The CPU must stall in the very cycle cs rises, hence combinational.
    assign cpu_wait     = ram_cs && (state_q != ST_DONE);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign cpu_data_out = cpu_data_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mapper_mem_responder.sv
module tb_mapper_mem_responder;

    localparam int AW = 27;
    localparam int TO = 8;
`ifdef MAPPER_LAST_READ_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          ram_cs;
    logic [AW-1:0] ram_addr;
    logic          ram_rnw;
    logic [7:0]    cpu_data_in;
    logic [7:0]    cpu_data_out;
    logic          cpu_wait;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          mem_ack;
    logic          timeout_err;

    mapper_mem_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ram_cs(ram_cs), .ram_addr(ram_addr),
        .ram_rnw(ram_rnw), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_wait(cpu_wait), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // One access is "in flight" from the edge that sees cs until ack/timeout,
    // then "completed" until cs is released.
    logic          m_inflight, m_completed;
    int            m_age;
    logic          e_req, e_we, e_terr;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din, e_data;
    logic          c_valid;
    logic [AW-1:0] c_tag;
    logic [7:0]    c_data;

    always @(posedge clk) begin
        if (reset) begin
            m_inflight <= 1'b0; m_completed <= 1'b0; m_age <= 0;
            e_req <= 1'b0; e_we <= 1'b0; e_addr <= '0; e_din <= 8'h00;
            e_data <= 8'hFF; e_terr <= 1'b0; c_valid <= 1'b0;
        end else if (m_inflight) begin
            e_terr <= 1'b0;
            if (mem_ack) begin
                m_inflight <= 1'b0; m_completed <= 1'b1; e_req <= 1'b0;
                if (!e_we) begin
                    e_data <= mem_dout; c_valid <= 1'b1; c_tag <= e_addr; c_data <= mem_dout;
                end else if (c_valid && c_tag == e_addr) begin
                    c_data <= e_din;
                end
            end else if (TO != 0 && m_age + 1 == TO) begin
                m_inflight <= 1'b0; m_completed <= 1'b1; e_req <= 1'b0;
                e_data <= 8'hFF; e_terr <= 1'b1; c_valid <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_completed) begin
            e_terr <= 1'b0;
            if (!ram_cs) m_completed <= 1'b0;
        end else begin
            e_terr <= 1'b0;
            if (ram_cs) begin
                if (CACHE && ram_rnw && c_valid && c_tag == ram_addr) begin
                    e_data <= c_data; m_completed <= 1'b1;
                end else begin
                    m_inflight <= 1'b1; m_age <= 0; e_req <= 1'b1;
                    e_addr <= ram_addr; e_we <= ~ram_rnw; e_din <= cpu_data_in;
                end
            end
        end
    end

    // ---------------- checking (single process: the initial block) ----------------
    int   checks, errors;
    bit   chk_en;
    int   req_cyc, wait_cyc, terr_cnt, req_rise;
    logic prev_req;
    logic          last_we;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        if (chk_en) begin
            chk("cpu_wait", 32'(cpu_wait), 32'(ram_cs && !m_completed && !reset ? 1'b1 : (ram_cs && !m_completed)));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("timeout_err", 32'(timeout_err), 32'(e_terr));
            chk("cpu_data_out", 32'(cpu_data_out), 32'(e_data));
            if (e_req) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_din", 32'(mem_din), 32'(e_din));
            end
            req_cyc  += int'(mem_req);
            wait_cyc += int'(cpu_wait);
            terr_cnt += int'(timeout_err);
            if (mem_req && !prev_req) req_rise++;
            if (mem_req) begin
                last_we = mem_we; last_addr = mem_addr; last_din = mem_din;
            end
            prev_req = mem_req;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        #1;
    endtask

    // One cs assertion; ack pulsed in cycle ack_at (-1 = never), cs dropped
    // from cycle drop_at (-1 = held), then held `hold` extra cycles with the
    // address/direction toggling.
    task automatic run_access(input logic [AW-1:0] a, input logic rnw, input logic [7:0] wd,
                              input logic [7:0] rd, input int ack_at, input int drop_at,
                              input int hold);
        int cyc;
        bit done;
        tick();
        ram_cs = 1'b1; ram_addr = a; ram_rnw = rnw; cpu_data_in = wd;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            mem_ack  = (cyc == ack_at);
            mem_dout = (cyc == ack_at) ? rd : 8'($urandom);
            if (drop_at >= 0 && cyc >= drop_at) begin
                ram_cs = 1'b0; ram_addr = '1;
            end
            tick();
            cyc++;
            if (cyc > ack_at && !mem_req && !(ram_cs && cpu_wait)) done = 1'b1;
        end
        mem_ack = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_bound cycles %0d limit 400", cyc);
        end
        for (int i = 0; i < hold && ram_cs; i++) begin
            ram_addr = AW'($urandom); ram_rnw = 1'($urandom); cpu_data_in = 8'($urandom);
            tick();
        end
        ram_cs = 1'b0; ram_addr = '1;
    endtask

    int r0, w0, t0, q0;
    task automatic snap();
        r0 = req_cyc; w0 = wait_cyc; t0 = terr_cnt; q0 = req_rise;
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        req_cyc = 0; wait_cyc = 0; terr_cnt = 0; req_rise = 0; prev_req = 1'b0;
        reset = 1'b1; ram_cs = 1'b0; ram_addr = '1; ram_rnw = 1'b1;
        cpu_data_in = 8'h00; mem_dout = 8'h00; mem_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        chk("rst_cpu_data", 32'(cpu_data_out), 32'h0FF);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk_en = 1'b1;

        // read 0x0004000, ack in cycle 3 with A5
        snap();
        run_access(27'h0004000, 1'b1, 8'h00, 8'hA5, 3, -1, 0);
        chk("rd_data", 32'(cpu_data_out), 32'h0A5);
        chk("rd_req_cycles", 32'(req_cyc - r0), 32'd3);
        chk("rd_wait_cycles", 32'(wait_cyc - w0), 32'd4);

        // write 3C to 0x0001234, ack in cycle 1
        snap();
        run_access(27'h0001234, 1'b0, 8'h3C, 8'h99, 1, -1, 0);
        chk("wr_we", 32'(last_we), 32'd1);
        chk("wr_din", 32'(last_din), 32'h03C);
        chk("wr_addr", 32'(last_addr), 32'h0001234);
        chk("wr_one_req", 32'(req_rise - q0), 32'd1);
        chk("wr_data_kept", 32'(cpu_data_out), 32'h0A5);

        // read with no ack: watchdog after TO BUSY cycles
        snap();
        run_access(27'h0000777, 1'b1, 8'h00, 8'h00, -1, -1, 2);
        chk("to_req_cycles", 32'(req_cyc - r0), 32'(TO));
        chk("to_pulses", 32'(terr_cnt - t0), 32'd1);
        chk("to_data", 32'(cpu_data_out), 32'h0FF);

        // ack in the very cycle the watchdog would expire: ack wins
        snap();
        run_access(27'h0000999, 1'b1, 8'h00, 8'h42, TO, -1, 0);
        chk("race_pulses", 32'(terr_cnt - t0), 32'd0);
        chk("race_data", 32'(cpu_data_out), 32'h042);

        // cs held 20 cycles with address toggling after ack
        snap();
        run_access(27'h0002222, 1'b0, 8'h77, 8'h00, 2, -1, 16);
        chk("hold_one_req", 32'(req_rise - q0), 32'd1);

        // cs dropped mid-BUSY: completes, back to idle
        snap();
        run_access(27'h0003333, 1'b1, 8'h00, 8'hC3, 4, 2, 0);
        chk("drop_data", 32'(cpu_data_out), 32'h0C3);
        chk("drop_one_req", 32'(req_rise - q0), 32'd1);

        // reset during BUSY, then stray ack
        tick();
        ram_cs = 1'b1; ram_addr = 27'h0000ABC; ram_rnw = 1'b1;
        tick();
        chk("rb_req_up", 32'(mem_req), 32'd1);
        reset = 1'b1; ram_cs = 1'b0; ram_addr = '1;
        tick();
        reset = 1'b0;
        chk("rb_req_low", 32'(mem_req), 32'd0);
        chk("rb_data", 32'(cpu_data_out), 32'h0FF);
        chk("rb_addr", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1; mem_dout = 8'h5C;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rb_ack_ignored", 32'(mem_req), 32'd0);
        chk("rb_data_kept", 32'(cpu_data_out), 32'h0FF);

`ifdef MAPPER_LAST_READ_CACHE_EN
        run_access(27'h0008000, 1'b1, 8'h00, 8'h5A, 2, -1, 0);
        snap();
        run_access(27'h0008000, 1'b1, 8'h00, 8'h00, -1, -1, 0);
        chk("c_hit_noreq", 32'(req_cyc - r0), 32'd0);
        chk("c_hit_wait", 32'(wait_cyc - w0), 32'd1);
        chk("c_hit_data", 32'(cpu_data_out), 32'h05A);
        run_access(27'h0008000, 1'b0, 8'h11, 8'h00, 1, -1, 0);
        snap();
        run_access(27'h0008000, 1'b1, 8'h00, 8'h00, -1, -1, 0);
        chk("c_wr_noreq", 32'(req_cyc - r0), 32'd0);
        chk("c_wr_data", 32'(cpu_data_out), 32'h011);
`endif

        // randomized accesses against the model
        for (int n = 0; n < 200; n++) begin
            logic [AW-1:0] a;
            int ack_at, drop_at;
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            ack_at  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
            drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
            run_access(a, 1'($urandom), 8'($urandom), 8'($urandom), ack_at, drop_at,
                       int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1; mem_dout = 8'($urandom);
                tick();
                mem_ack = 1'b0;
            end
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mapper_mem_responder.md
Name: mapper_mem_responder

Overview:
- Memory-side responder for mapper outputs: takes the mapper's ram_cs/addr/rnw plus CPU write data and runs exactly one memory-controller transaction per chip-select assertion.
- Drives CPU wait until the transaction completes, then returns read data.
- Sits between the slot mapper mux and the SDRAM/BRAM request port.
- A watchdog aborts hung transactions.

Parameters:
- ADDR_WIDTH, 27, width of ram_addr/mem_addr; matches the mapper output address.
- TIMEOUT_CYCLES, 255, maximum cycles in BUSY waiting for mem_ack; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ram_cs  in  1  mapper chip select; level, held for the whole CPU bus cycle
- ram_addr  in  ADDR_WIDTH  mapper address; all-ones when not selected
- ram_rnw  in  1  1 = read, 0 = write
- cpu_data_in  in  8  CPU write data
- cpu_data_out  out  8  read data to CPU; registered
- cpu_wait  out  1  CPU stall request; combinational
- mem_req  out  1  memory request; level, registered
- mem_we  out  1  1 = write; valid while mem_req
- mem_addr  out  ADDR_WIDTH  latched address; valid while mem_req
- mem_din  out  8  latched write data; valid while mem_req
- mem_dout  in  8  read data; valid in the mem_ack cycle
- mem_ack  in  1  single-cycle completion pulse
- timeout_err  out  1  single-cycle pulse on watchdog abort

Behaviour:
- Reset values: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, cpu_data_out=8'hFF, timeout_err=0, watchdog counter=0.
- cpu_wait = ram_cs && (state != DONE). This is the only combinational output, so the CPU stalls in the same cycle cs rises.
- IDLE, on ram_cs=1:
  - latch ram_addr into mem_addr, ~ram_rnw into mem_we, cpu_data_in into mem_din
  - mem_req<=1, clear watchdog, go to BUSY
  - mem_req is visible one cycle after cs.
- BUSY:
  - mem_req stays high and mem_addr/mem_we/mem_din stay stable until the transaction ends.
  - Watchdog increments every cycle.
  - On mem_ack: mem_req<=0; on a read, cpu_data_out<=mem_dout (writes leave cpu_data_out unchanged); go to DONE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no ack (and TIMEOUT_CYCLES != 0): mem_req<=0, cpu_data_out<=8'hFF, timeout_err<=1 for one cycle, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and there is no error pulse.
- DONE: cpu_wait is low. Stay while ram_cs=1; go to IDLE on ram_cs=0.
- Latency: ack sampled at edge n gives data/DONE/cpu_wait=0 at n+1. Minimum cs-to-wait-release is 2 cycles.
- ram_cs falling during BUSY does not abort the transaction. It completes normally, then DONE exits to IDLE on the next edge.
- Changes to ram_addr/ram_rnw while cs is held in BUSY or DONE are ignored: one access per cs assertion.
- mem_ack outside BUSY is ignored.
- ram_cs re-asserting on the cycle after DONE→IDLE starts a new access normally.
- Reset mid-BUSY: mem_req is low on the next cycle, and a later stray ack is ignored.

Optional Feature:
- Macro: MAPPER_LAST_READ_CACHE_EN. Enables a single-entry last-read cache (valid, tag, data).
- With the macro defined:
  - IDLE, read, valid && tag==ram_addr: cpu_data_out<=cached data, go directly to DONE, mem_req never asserts (1 wait cycle).
  - Completed read fills the entry with tag=addr, data=mem_dout, valid=1.
  - Completed write to the tag address updates the cached data with mem_din.
  - A timeout or reset clears valid.
- Without the macro: every access issues mem_req, and the cache logic is absent.

Test Plan:
- Read at addr 27'h0004000, ack after 3 cycles with mem_dout=8'hA5 → mem_req cycles 1–3, mem_we=0, cpu_data_out=8'hA5 and cpu_wait=0 from cycle 4, cpu_wait=1 cycles 0–3.
- Write 8'h3C to 27'h0001234, ack after 1 cycle → mem_we=1, mem_din=8'h3C, one mem_req per cs, cpu_data_out unchanged.
- Read with no ack, TIMEOUT_CYCLES=8 → mem_req drops after 8 BUSY cycles, timeout_err pulses once, cpu_data_out=8'hFF.
- ram_cs held 20 cycles while ram_addr toggles after ack → exactly one mem_req. ram_cs dropped mid-BUSY → access completes, return to IDLE.
- Reset asserted during BUSY, then ack → mem_req=0 next cycle, outputs at reset values, ack ignored.
- With MAPPER_LAST_READ_CACHE_EN: two reads of 27'h0008000 (first returns 8'h5A) → second read has no mem_req, 1 wait cycle, data 8'h5A. A write of 8'h11 to the same address, then a read → cached 8'h11.
